// File: rtl/tmr_pkg.sv
// Shared types and helpers for the triplicated scrubbed register.
package tmr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPAIR = 2'd2,
        REPORT = 2'd3
    } tmr_scrub_state_t;

    localparam int REPLICA_0     = 0;
    localparam int REPLICA_1     = 1;
    localparam int REPLICA_2     = 2;
    localparam int REPLICA_COUNT = 3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter.
module tmr_voter
    import tmr_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        for (int k = 0; k < WIDTH; k++) begin
            o_y[k] = maj3(i_a[k], i_b[k], i_c[k]);
        end
    end

endmodule

// File: rtl/tmr_scrub_reg.sv
// Triplicated register with periodic scrub, upset reporting and saturating upset counters.
// Optional fault-injection ports are enabled with `define TMR_SCRUB_INJECT_EN.
module tmr_scrub_reg
    import tmr_pkg::*;
#(
    parameter int bits         = 1,
    parameter int SCRUB_PERIOD = 16,
    parameter int CNT_W        = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_we,
    input  logic [bits-1:0]                   i_d,
    output logic [bits-1:0]                   o_q,
    input  logic                              i_scrub_now,
    output logic                              o_err_valid,
    input  logic                              i_err_ready,
    output logic [2:0]                        o_err_replica,
    output logic [REPLICA_COUNT-1:0][CNT_W-1:0] o_err_cnt,
    input  logic                              i_cnt_clr
`ifdef TMR_SCRUB_INJECT_EN
    ,
    input  logic                              i_inj_en,
    input  logic [1:0]                        i_inj_sel,
    input  logic [bits-1:0]                   i_inj_mask
`endif
);

    localparam int TIMER_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(SCRUB_PERIOD - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

    (* dont_touch = "true" *) logic [bits-1:0] r_rep0;
    (* dont_touch = "true" *) logic [bits-1:0] r_rep1;
    (* dont_touch = "true" *) logic [bits-1:0] r_rep2;

    logic [bits-1:0]    w_rep0_next;
    logic [bits-1:0]    w_rep1_next;
    logic [bits-1:0]    w_rep2_next;
    logic [bits-1:0]    w_q;
    logic [2:0]         w_mismatch;

    tmr_scrub_state_t   r_state;
    tmr_scrub_state_t   w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic [2:0]         r_err_replica;
    logic [2:0]         w_err_replica_next;

    logic [REPLICA_COUNT-1:0][CNT_W-1:0] r_cnt;
    logic [REPLICA_COUNT-1:0][CNT_W-1:0] w_cnt_next;

    tmr_voter #(
        .WIDTH (bits)
    ) u_voter (
        .i_a (r_rep0),
        .i_b (r_rep1),
        .i_c (r_rep2),
        .o_y (w_q)
    );

    always_comb begin
        w_mismatch            = '0;
        w_mismatch[REPLICA_0] = |(r_rep0 ^ w_q);
        w_mismatch[REPLICA_1] = |(r_rep1 ^ w_q);
        w_mismatch[REPLICA_2] = |(r_rep2 ^ w_q);
    end

    // Priority, lowest to highest: hold, injected upset, scrub rewrite, host write.
    always_comb begin
        w_rep0_next = r_rep0;
        w_rep1_next = r_rep1;
        w_rep2_next = r_rep2;
`ifdef TMR_SCRUB_INJECT_EN
        if (i_inj_en) begin
            case (i_inj_sel)
                2'd0:    w_rep0_next = r_rep0 ^ i_inj_mask;
                2'd1:    w_rep1_next = r_rep1 ^ i_inj_mask;
                2'd2:    w_rep2_next = r_rep2 ^ i_inj_mask;
                default: ;
            endcase
        end
`endif
        if (r_state == REPAIR) begin
            w_rep0_next = w_q;
            w_rep1_next = w_q;
            w_rep2_next = w_q;
        end
        if (i_we) begin
            w_rep0_next = i_d;
            w_rep1_next = i_d;
            w_rep2_next = i_d;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_timer_next       = r_timer;
        w_err_replica_next = r_err_replica;
        case (r_state)
            IDLE: begin
                if (r_timer != '0) begin
                    w_timer_next = r_timer - TIMER_W'(1);
                end
                if ((r_timer == '0) || i_scrub_now) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (w_mismatch == 3'b000) begin
                    w_state_next = IDLE;
                    w_timer_next = TIMER_RELOAD;
                end else begin
                    w_err_replica_next = w_mismatch;
                    w_state_next       = REPAIR;
                end
            end
            REPAIR: begin
                w_state_next = REPORT;
            end
            REPORT: begin
                if (i_err_ready) begin
                    w_state_next       = IDLE;
                    w_timer_next       = TIMER_RELOAD;
                    w_err_replica_next = 3'b000;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_timer_next = TIMER_RELOAD;
            end
        endcase
    end

    // A clear in the same cycle as a repair increment wins.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_state == REPAIR) begin
            for (int i = 0; i < REPLICA_COUNT; i++) begin
                if (r_err_replica[i] && (r_cnt[i] != CNT_MAX)) begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
        if (i_cnt_clr) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep0        <= '0;
            r_rep1        <= '0;
            r_rep2        <= '0;
            r_state       <= IDLE;
            r_timer       <= TIMER_RELOAD;
            r_err_replica <= 3'b000;
            r_cnt         <= '0;
        end else begin
            r_rep0        <= w_rep0_next;
            r_rep1        <= w_rep1_next;
            r_rep2        <= w_rep2_next;
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_err_replica <= w_err_replica_next;
            r_cnt         <= w_cnt_next;
        end
    end

    assign o_q           = w_q;
    assign o_err_valid   = (r_state == REPORT);
    assign o_err_replica = r_err_replica;
    assign o_err_cnt     = r_cnt;

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Scoreboard bench for tmr_scrub_reg (bits=8, SCRUB_PERIOD=4, CNT_W=4).
// Upsets use the injection ports when TMR_SCRUB_INJECT_EN is defined, otherwise a force on the replica.
module tb_tmr_scrub_reg;

    localparam int B = 8;
    localparam int P = 4;
    localparam int C = 4;

    localparam int S_IDLE   = 0;
    localparam int S_CHECK  = 1;
    localparam int S_REPAIR = 2;
    localparam int S_REPORT = 3;

    typedef struct packed {
        logic [B-1:0] q;
        logic         valid;
        logic [2:0]   rep;
        logic [C-1:0] c0;
        logic [C-1:0] c1;
        logic [C-1:0] c2;
    } expect_t;

    logic              clock;
    logic              reset;
    logic              we;
    logic [B-1:0]      d;
    logic [B-1:0]      q;
    logic              scrubNow;
    logic              errValid;
    logic              errReady;
    logic [2:0]        errReplica;
    logic [2:0][C-1:0] errCnt;
    logic              cntClr;
`ifdef TMR_SCRUB_INJECT_EN
    logic              injEn;
    logic [1:0]        injSel;
    logic [B-1:0]      injMask;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int sawValid;

    logic [B-1:0] mRep [3];
    int           mState;
    int           mTimer;
    logic [2:0]   mErrRep;
    logic [C-1:0] mCnt [3];
    expect_t      expQ [$];

    tmr_scrub_reg #(
        .bits         (B),
        .SCRUB_PERIOD (P),
        .CNT_W        (C)
    ) dut (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_we          (we),
        .i_d           (d),
        .o_q           (q),
        .i_scrub_now   (scrubNow),
        .o_err_valid   (errValid),
        .i_err_ready   (errReady),
        .o_err_replica (errReplica),
        .o_err_cnt     (errCnt),
        .i_cnt_clr     (cntClr)
`ifdef TMR_SCRUB_INJECT_EN
        ,
        .i_inj_en      (injEn),
        .i_inj_sel     (injSel),
        .i_inj_mask    (injMask)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [B-1:0] maj(input logic [B-1:0] a, input logic [B-1:0] b,
                                         input logic [B-1:0] c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference behaviour for one rising edge; pushes the outputs expected after it.
    task automatic modelStep(input logic iRst, input logic iWe, input logic [B-1:0] iD,
                             input logic iScrub, input logic iReady, input logic iClr,
                             input logic iInj, input logic [1:0] iSel, input logic [B-1:0] iMask);
        logic [B-1:0] v;
        logic [2:0]   m;
        logic [B-1:0] nRep [3];
        int           nState;
        int           nTimer;
        logic [2:0]   nErr;
        logic [C-1:0] nCnt [3];
        expect_t      e;
        if (iRst) begin
            for (int i = 0; i < 3; i++) begin
                mRep[i] = '0;
                mCnt[i] = '0;
            end
            mState  = S_IDLE;
            mTimer  = P - 1;
            mErrRep = 3'b000;
        end else begin
            v = maj(mRep[0], mRep[1], mRep[2]);
            for (int i = 0; i < 3; i++) m[i] = |(mRep[i] ^ v);
            nRep   = mRep;
            nCnt   = mCnt;
            nState = mState;
            nTimer = mTimer;
            nErr   = mErrRep;
            if (iInj && iSel != 2'd3) nRep[iSel] = mRep[iSel] ^ iMask;
            if (mState == S_REPAIR) for (int i = 0; i < 3; i++) nRep[i] = v;
            if (iWe) for (int i = 0; i < 3; i++) nRep[i] = iD;
            case (mState)
                S_IDLE: begin
                    if (mTimer != 0) nTimer = mTimer - 1;
                    if (mTimer == 0 || iScrub) nState = S_CHECK;
                end
                S_CHECK: begin
                    if (m == 3'b000) begin
                        nState = S_IDLE;
                        nTimer = P - 1;
                    end else begin
                        nErr   = m;
                        nState = S_REPAIR;
                    end
                end
                S_REPAIR: begin
                    for (int i = 0; i < 3; i++)
                        if (mErrRep[i] && mCnt[i] != {C{1'b1}}) nCnt[i] = mCnt[i] + 1'b1;
                    nState = S_REPORT;
                end
                default: begin
                    if (iReady) begin
                        nState = S_IDLE;
                        nTimer = P - 1;
                        nErr   = 3'b000;
                    end
                end
            endcase
            if (iClr) for (int i = 0; i < 3; i++) nCnt[i] = '0;
            mRep = nRep; mCnt = nCnt; mState = nState; mTimer = nTimer; mErrRep = nErr;
        end
        e.q     = maj(mRep[0], mRep[1], mRep[2]);
        e.valid = (mState == S_REPORT);
        e.rep   = mErrRep;
        e.c0    = mCnt[0];
        e.c1    = mCnt[1];
        e.c2    = mCnt[2];
        expQ.push_back(e);
    endtask

    task automatic checkStep();
        expect_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput("q", 32'(q), 32'(e.q));
            checkOutput("err_valid", 32'(errValid), 32'(e.valid));
            checkOutput("err_replica", 32'(errReplica), 32'(e.rep));
            checkOutput("err_cnt0", 32'(errCnt[0]), 32'(e.c0));
            checkOutput("err_cnt1", 32'(errCnt[1]), 32'(e.c1));
            checkOutput("err_cnt2", 32'(errCnt[2]), 32'(e.c2));
        end
    endtask

    task automatic applyStimulus(input logic iRst, input logic iWe, input logic [B-1:0] iD,
                                 input logic iScrub, input logic iReady, input logic iClr,
                                 input logic iInj, input logic [1:0] iSel, input logic [B-1:0] iMask);
        @(negedge clock);
        reset    = iRst;
        we       = iWe;
        d        = iD;
        scrubNow = iScrub;
        errReady = iReady;
        cntClr   = iClr;
`ifdef TMR_SCRUB_INJECT_EN
        injEn    = iInj;
        injSel   = iSel;
        injMask  = iMask;
`else
        if (iInj && !iRst && !iWe) begin
            case (iSel)
                2'd0: begin force dut.r_rep0 = mRep[0] ^ iMask; release dut.r_rep0; end
                2'd1: begin force dut.r_rep1 = mRep[1] ^ iMask; release dut.r_rep1; end
                2'd2: begin force dut.r_rep2 = mRep[2] ^ iMask; release dut.r_rep2; end
                default: ;
            endcase
        end
`endif
        modelStep(iRst, iWe, iD, iScrub, iReady, iClr, iInj, iSel, iMask);
        @(posedge clock);
        #1;
        checkStep();
    endtask

    task automatic tick(input logic iReady);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, iReady, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic scrub();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    // Upsets are only planted while idle so the next check sees them whole.
    task automatic upset(input logic [1:0] sel, input logic [B-1:0] mask);
        int n = 0;
        while (mState != S_IDLE && n < 20) begin
            tick(1'b1);
            n++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, sel, mask);
    endtask

    task automatic waitState(input int target, input logic iReady);
        int n = 0;
        while (mState != target && n < 40) begin
            tick(iReady);
            n++;
        end
        if (mState != target) checkOutput("wait_state_timeout", 32'(mState), 32'(target));
    endtask

    task automatic waitFreshIdle();
        int n = 0;
        while (!(mState == S_IDLE && mTimer == P - 1) && n < 40) begin
            tick(1'b1);
            n++;
        end
        if (n >= 40) checkOutput("wait_idle_timeout", 32'(mTimer), 32'(P - 1));
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; d = '0; scrubNow = 1'b0; errReady = 1'b0; cntClr = 1'b0;
`ifdef TMR_SCRUB_INJECT_EN
        injEn = 1'b0; injSel = 2'd0; injMask = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            mRep[i] = 'x;
            mCnt[i] = 'x;
        end
        mState = S_IDLE; mTimer = P - 1; mErrRep = 3'b000;

        $display("[TB] reset and initial write");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        checkOutput("reset_q", 32'(q), 32'h0);
        checkOutput("reset_valid", 32'(errValid), 32'h0);
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0);
        checkOutput("write_q", 32'(q), 32'hA5);
        sawValid = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            if (errValid) sawValid++;
        end
        checkOutput("clean_checks_no_report", 32'(sawValid), 32'd0);

        $display("[TB] single upset on replica 1, held report");
        upset(2'd1, 8'h01);
        checkOutput("masked_q", 32'(q), 32'hA5);
        waitState(S_REPORT, 1'b0);
        checkOutput("s2_replica", 32'(errReplica), 32'b010);
        checkOutput("s2_cnt1", 32'(errCnt[1]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            checkOutput("s2_held_replica", 32'(errReplica), 32'b010);
        end
        tick(1'b1);
        sawValid = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            if (errValid) sawValid++;
        end
        checkOutput("s2_after_repair_clean", 32'(sawValid), 32'd0);

        $display("[TB] double upset on replicas 0 and 2 with scrub_now");
        waitFreshIdle();
        upset(2'd0, 8'h01);
        upset(2'd2, 8'h80);
        checkOutput("s3_q", 32'(q), 32'hA5);
        scrub();
        waitState(S_REPORT, 1'b0);
        checkOutput("s3_replica", 32'(errReplica), 32'b101);
        checkOutput("s3_cnt0", 32'(errCnt[0]), 32'd1);
        checkOutput("s3_cnt2", 32'(errCnt[2]), 32'd1);
        checkOutput("s3_q_after", 32'(q), 32'hA5);
        tick(1'b1);

        $display("[TB] counter saturation and clear");
        for (int k = 0; k < 20; k++) begin
            upset(2'd1, 8'h01);
            scrub();
            waitState(S_REPORT, 1'b0);
            tick(1'b1);
        end
        checkOutput("s4_saturated", 32'(errCnt[1]), 32'd15);
        upset(2'd1, 8'h01);
        scrub();
        waitState(S_REPAIR, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
        checkOutput("s4_cleared", 32'(errCnt[1]), 32'd0);
        tick(1'b1);

        $display("[TB] host write during repair");
        upset(2'd0, 8'h01);
        scrub();
        waitState(S_REPAIR, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        checkOutput("s5_q", 32'(q), 32'h3C);
        checkOutput("s5_replica", 32'(errReplica), 32'b001);
        tick(1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1);

        $display("[TB] reset during pending report");
        upset(2'd2, 8'h10);
        scrub();
        waitState(S_REPORT, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        checkOutput("s6_valid", 32'(errValid), 32'h0);
        checkOutput("s6_replica", 32'(errReplica), 32'h0);
        checkOutput("s6_q", 32'(q), 32'h0);
        sawValid = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            if (errValid) sawValid++;
        end
        checkOutput("s6_no_stale_report", 32'(sawValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
